// File: rtl/text_console_writer.sv
// Text console writer: turns a byte stream into text-memory writes,
// tracking the cursor and handling CR/LF/BS/FF, clear and scroll.
module text_console_writer #(
   parameter int         COLS      = 80,
   parameter int         ROWS      = 25,
   parameter logic [7:0] FILL_CHAR = 8'h20
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  attr,
   input  logic        page,
   output logic [12:0] mem_address,
   output logic [7:0]  mem_data_o,
   output logic        mem_wren,
   input  logic [7:0]  mem_data_i,
   output logic [6:0]  cursor_x,
   output logic [4:0]  cursor_y,
   output logic        busy
);

   localparam logic [3:0] S_IDLE    = 4'd0;
   localparam logic [3:0] S_PUT_CH  = 4'd1;
   localparam logic [3:0] S_PUT_AT  = 4'd2;
   localparam logic [3:0] S_ADV     = 4'd3;
   localparam logic [3:0] S_SCR_RD  = 4'd4;
   localparam logic [3:0] S_SCR_WR  = 4'd5;
   localparam logic [3:0] S_FILL_CH = 4'd6;
   localparam logic [3:0] S_FILL_AT = 4'd7;
   localparam logic [3:0] S_CLR     = 4'd8;

   localparam logic [6:0]  XMAX      = 7'(COLS - 1);
   localparam logic [4:0]  YMAX      = 5'(ROWS - 1);
   localparam logic [11:0] ROWB      = 12'(2 * COLS);
   localparam logic [11:0] SCR_LAST  = 12'(2 * COLS * (ROWS - 1) - 1);
   localparam logic [11:0] FILL_BASE = 12'(2 * COLS * (ROWS - 1));
   localparam logic [11:0] LAST      = 12'(2 * COLS * ROWS - 1);

   logic [3:0]  state_q, state_d;
   logic [6:0]  x_q, x_d;
   logic [4:0]  y_q, y_d;
   logic [7:0]  at_q, at_d;
   logic        pg_q, pg_d;
   logic [11:0] off_q, off_d;
   logic [11:0] cnt_q, cnt_d;
   logic [7:0]  wdat_q, wdat_d;
   logic        wren_q, wren_d;
   logic        hold_q, hold_d;
   logic        accept;
   logic [11:0] cell_off;

   assign accept   = in_valid & in_ready;
   assign cell_off = 12'(y_q) * ROWB + {4'd0, x_q, 1'b0};

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      at_d    = at_q;
      pg_d    = pg_q;
      off_d   = off_q;
      cnt_d   = cnt_q;
      wdat_d  = wdat_q;
      wren_d  = 1'b0;
      hold_d  = 1'b0;
      case (state_q)
         S_IDLE: if (accept) begin
            at_d = attr;
            pg_d = page;
            unique case (1'b1)
               in_data == 8'h0D: begin
                  x_d    = '0;
                  hold_d = 1'b1;
               end
               in_data == 8'h0A: begin
                  x_d = '0;
                  if (y_q < YMAX) begin
                     y_d    = y_q + 5'd1;
                     hold_d = 1'b1;
                  end else begin
                     state_d = S_SCR_RD;
                     cnt_d   = '0;
                     off_d   = ROWB;
                  end
               end
               in_data == 8'h08: begin
                  hold_d = 1'b1;
                  if (x_q != '0) begin
                     x_d = x_q - 7'd1;
                  end else if (y_q != '0) begin
                     x_d = XMAX;
                     y_d = y_q - 5'd1;
                  end
               end
               in_data == 8'h0C: begin
                  state_d = S_CLR;
                  off_d   = '0;
                  wdat_d  = FILL_CHAR;
                  wren_d  = 1'b1;
               end
               default: begin
                  state_d = S_PUT_CH;
                  off_d   = cell_off;
                  wdat_d  = in_data;
                  wren_d  = 1'b1;
               end
            endcase
         end
         S_PUT_CH: begin
            state_d = S_PUT_AT;
            off_d   = off_q + 12'd1;
            wdat_d  = at_q;
            wren_d  = 1'b1;
         end
         S_PUT_AT: state_d = S_ADV;
         S_ADV: begin
            state_d = S_IDLE;
            if (x_q < XMAX) begin
               x_d = x_q + 7'd1;
            end else begin
               x_d = '0;
               if (y_q < YMAX) begin
                  y_d = y_q + 5'd1;
               end else begin
                  state_d = S_SCR_RD;
                  cnt_d   = '0;
                  off_d   = ROWB;
               end
            end
         end
         S_SCR_RD: begin
            state_d = S_SCR_WR;
            off_d   = cnt_q;
            wren_d  = 1'b1;
         end
         S_SCR_WR: begin
            if (cnt_q == SCR_LAST) begin
               state_d = S_FILL_CH;
               off_d   = FILL_BASE;
               wdat_d  = FILL_CHAR;
               wren_d  = 1'b1;
            end else begin
               state_d = S_SCR_RD;
               cnt_d   = cnt_q + 12'd1;
               off_d   = cnt_q + 12'd1 + ROWB;
            end
         end
         S_FILL_CH: begin
            state_d = S_FILL_AT;
            off_d   = off_q + 12'd1;
            wdat_d  = at_q;
            wren_d  = 1'b1;
         end
         S_FILL_AT: begin
            if (off_q == LAST) begin
               state_d = S_IDLE;
               x_d     = '0;
               y_d     = YMAX;
            end else begin
               state_d = S_FILL_CH;
               off_d   = off_q + 12'd1;
               wdat_d  = FILL_CHAR;
               wren_d  = 1'b1;
            end
         end
         S_CLR: begin
            if (off_q == LAST) begin
               state_d = S_IDLE;
               x_d     = '0;
               y_d     = '0;
            end else begin
               off_d  = off_q + 12'd1;
               wdat_d = off_q[0] ? FILL_CHAR : at_q;
               wren_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         at_q    <= '0;
         pg_q    <= 1'b0;
         off_q   <= '0;
         cnt_q   <= '0;
         wdat_q  <= '0;
         wren_q  <= 1'b0;
         hold_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         at_q    <= at_d;
         pg_q    <= pg_d;
         off_q   <= off_d;
         cnt_q   <= cnt_d;
         wdat_q  <= wdat_d;
         wren_q  <= wren_d;
         hold_q  <= hold_d;
      end
   end

   // Scroll copies the byte returned for the previous cycle's read address
   assign mem_data_o  = (state_q == S_SCR_WR) ? mem_data_i : wdat_q;
   assign mem_address = {pg_q, off_q};
   assign mem_wren    = wren_q;
   assign in_ready    = (state_q == S_IDLE) & ~hold_q;
   assign busy        = ~in_ready;
   assign cursor_x    = x_q;
   assign cursor_y    = y_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Bench for text_console_writer: vector table plus write scoreboard
// against a synchronous-read model of the text memory.
module tb_text_console_writer;

   typedef struct {
      logic [7:0] ch;
      logic [7:0] at;
      logic       pg;
      int         rep;
      int         ex;
      int         ey;
      int         eb;
   } vec_t;

   typedef struct {
      logic [12:0] a;
      logic [7:0]  d;
   } wr_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  attr;
   logic        page;
   logic [12:0] mem_address;
   logic [7:0]  mem_data_o;
   logic        mem_wren;
   logic [7:0]  mem_data_i;
   logic [6:0]  cursor_x;
   logic [4:0]  cursor_y;
   logic        busy;

   logic [7:0] mem  [8192];
   logic [7:0] refm [8192];
   logic [7:0] snap [4096];
   logic [7:0] rdq;
   wr_t        sbq[$];
   int         total = 0;
   int         bad = 0;
   int         mx = 0;
   int         my = 0;

   text_console_writer dut (
      .clock(clk), .reset(reset),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .attr(attr), .page(page),
      .mem_address(mem_address), .mem_data_o(mem_data_o),
      .mem_wren(mem_wren), .mem_data_i(mem_data_i),
      .cursor_x(cursor_x), .cursor_y(cursor_y), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_wren) mem[mem_address] <= mem_data_o;
      rdq <= mem[mem_address];
   end
   assign mem_data_i = rdq;

   always @(negedge clk) begin
      if (!reset && mem_wren) begin
         total++;
         if (sbq.size() == 0) begin
            bad++;
            $display("FAIL wr_unexpected addr=%h data=%h",
                     mem_address, mem_data_o);
         end else begin
            wr_t e;
            e = sbq.pop_front();
            if (e.a !== mem_address || e.d !== mem_data_o) begin
               bad++;
               $display("FAIL wr got=%h/%h want=%h/%h",
                        mem_address, mem_data_o, e.a, e.d);
            end
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", nm, act, exp);
      end
   endtask

   task automatic push(input logic [12:0] a, input logic [7:0] d);
      wr_t e;
      e.a = a;
      e.d = d;
      sbq.push_back(e);
      refm[a] = d;
   endtask

   task automatic scroll_model(input logic [7:0] a, input logic p);
      for (int i = 0; i < 3840; i++)
         push({p, 12'(i)}, refm[{p, 12'(i + 160)}]);
      for (int i = 3840; i < 4000; i++)
         push({p, 12'(i)}, (i % 2 == 0) ? 8'h20 : a);
      mx = 0;
      my = 24;
   endtask

   task automatic model(input logic [7:0] c, input logic [7:0] a,
                        input logic p);
      logic [11:0] o;
      case (c)
         8'h0D: mx = 0;
         8'h0A: begin
            mx = 0;
            if (my < 24) my++;
            else scroll_model(a, p);
         end
         8'h08: begin
            if (mx > 0) mx--;
            else if (my > 0) begin
               mx = 79;
               my--;
            end
         end
         8'h0C: begin
            for (int i = 0; i < 4000; i++)
               push({p, 12'(i)}, (i % 2 == 0) ? 8'h20 : a);
            mx = 0;
            my = 0;
         end
         default: begin
            o = 12'((my * 80 + mx) * 2);
            push({p, o}, c);
            push({p, o + 12'd1}, a);
            if (mx < 79) mx++;
            else begin
               mx = 0;
               if (my < 24) my++;
               else scroll_model(a, p);
            end
         end
      endcase
   endtask

   task automatic send(input logic [7:0] c, input logic [7:0] a,
                       input logic p, output int bc);
      int n;
      n = 0;
      while (!in_ready && n < 20000) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         total++;
         bad++;
         $display("FAIL ready_wait got=0 want=1");
      end
      model(c, a, p);
      in_data  = c;
      attr     = a;
      page     = p;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      bc = 0;
      while (!in_ready && bc < 20000) begin
         bc++;
         @(negedge clk);
      end
   endtask

   vec_t tv[17];

   initial begin
      int bc;
      int errs;
      tv[0]  = '{8'h41, 8'h1F, 1'b0, 1,  1,  0, 3};
      tv[1]  = '{8'h0D, 8'h1F, 1'b0, 1,  0,  0, 1};
      tv[2]  = '{8'h0A, 8'h1F, 1'b0, 1,  0,  1, 1};
      tv[3]  = '{8'h55, 8'h1F, 1'b0, 1,  1,  1, 3};
      tv[4]  = '{8'h0D, 8'h1F, 1'b0, 1,  0,  1, 1};
      tv[5]  = '{8'h0A, 8'h1F, 1'b0, 2,  0,  3, 1};
      tv[6]  = '{8'h61, 8'h1F, 1'b0, 79, 79, 3, 3};
      tv[7]  = '{8'h5A, 8'h1F, 1'b0, 1,  0,  4, 3};
      tv[8]  = '{8'h0A, 8'h1F, 1'b0, 20, 0,  24, 1};
      tv[9]  = '{8'h0A, 8'h1F, 1'b0, 1,  0,  24, 7840};
      tv[10] = '{8'h0C, 8'h07, 1'b1, 1,  0,  0, 4000};
      tv[11] = '{8'h08, 8'h07, 1'b0, 1,  0,  0, 1};
      tv[12] = '{8'h0A, 8'h07, 1'b0, 5,  0,  5, 1};
      tv[13] = '{8'h08, 8'h07, 1'b0, 1,  79, 4, 1};
      tv[14] = '{8'h08, 8'h07, 1'b0, 1,  78, 4, 1};
      tv[15] = '{8'h01, 8'h2E, 1'b0, 1,  79, 4, 3};
      tv[16] = '{8'h1B, 8'h2E, 1'b0, 1,  0,  5, 3};

      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      attr     = '0;
      page     = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      refm = mem;
      chk("rst_x", int'(cursor_x), 0);
      chk("rst_y", int'(cursor_y), 0);
      chk("rst_wren", int'(mem_wren), 0);
      chk("rst_addr", int'(mem_address), 0);
      chk("rst_data", int'(mem_data_o), 0);
      chk("rst_ready", int'(in_ready), 1);
      chk("rst_busy", int'(busy), 0);

      for (int k = 0; k < 17; k++) begin
         if (k == 10)
            for (int i = 0; i < 4096; i++) snap[i] = mem[i];
         for (int r = 0; r < tv[k].rep; r++)
            send(tv[k].ch, tv[k].at, tv[k].pg, bc);
         chk($sformatf("v%0d_x", k), int'(cursor_x), tv[k].ex);
         chk($sformatf("v%0d_y", k), int'(cursor_y), tv[k].ey);
         chk($sformatf("v%0d_busy", k), bc, tv[k].eb);
         if (k == 0) begin
            chk("a_char", int'(mem[0]), 8'h41);
            chk("a_attr", int'(mem[1]), 8'h1F);
         end
         if (k == 7) begin
            chk("z_char", int'(mem[13'h27E]), 8'h5A);
            chk("z_attr", int'(mem[13'h27F]), 8'h1F);
         end
         if (k == 9) begin
            chk("scr_cell0", int'(mem[0]), 8'h55);
            errs = 0;
            for (int i = 3840; i < 4000; i++)
               if (mem[i] !== ((i % 2 == 0) ? 8'h20 : 8'h1F)) errs++;
            chk("scr_row24", errs, 0);
         end
         if (k == 10) begin
            errs = 0;
            for (int i = 0; i < 4000; i++)
               if (mem[4096 + i] !== ((i % 2 == 0) ? 8'h20 : 8'h07))
                  errs++;
            chk("clr_page1", errs, 0);
            errs = 0;
            for (int i = 0; i < 4096; i++)
               if (mem[i] !== snap[i]) errs++;
            chk("clr_page0", errs, 0);
         end
      end

      for (int r = 0; r < 19; r++) send(8'h0A, 8'h1F, 1'b0, bc);
      chk("pre_scr_y", int'(cursor_y), 24);
      model(8'h0A, 8'h1F, 1'b0);
      in_data  = 8'h0A;
      attr     = 8'h1F;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (1000) @(negedge clk);
      chk("mid_scr_busy", int'(busy), 1);
      @(posedge clk);
      #2;
      reset = 1'b1;
      sbq.delete();
      #1;
      chk("abort_wren", int'(mem_wren), 0);
      chk("abort_x", int'(cursor_x), 0);
      chk("abort_y", int'(cursor_y), 0);
      @(negedge clk);
      chk("abort_wren2", int'(mem_wren), 0);
      reset = 1'b0;
      mx = 0;
      my = 0;
      @(negedge clk);
      refm = mem;
      chk("post_rst_ready", int'(in_ready), 1);
      send(8'h42, 8'h4E, 1'b0, bc);
      chk("post_rst_x", int'(cursor_x), 1);
      chk("post_rst_busy", bc, 3);
      chk("post_rst_cell", int'(mem[0]), 8'h42);

      repeat (3) @(negedge clk);
      chk("sb_empty", sbq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
